// File: rtl/fifo_status_ctrl_if.sv
// Handshake/status bundle between requesting logic and fifo_status_ctrl.
// master: requester side (drives wr, rd, clr_err; observes status).
// slave : controller side (consumes requests; drives enables, pointers, flags).
//   wr, rd, clr_err      - write/read requests, sticky-error clear
//   fifo_we, fifo_rd     - gated storage-array enables
//   wptr, rptr           - ADDR_W+1 bit pointers (MSB = wrap bit)
//   count                - fill level 0..2**ADDR_W
//   full, empty, almost_full, almost_empty, overflow, underflow - status flags
interface fifo_status_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr;
  logic              rd;
  logic              clr_err;
  logic              fifo_we;
  logic              fifo_rd;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, rd, clr_err,
    input  fifo_we, fifo_rd, wptr, rptr, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output fifo_we, fifo_rd, wptr, rptr, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_status_ctrl.sv
// Pointer and status controller for a single-clock FIFO of depth 2**ADDR_W.
// Owns the write/read pointers, gates raw wr/rd into storage enables and
// derives fill count, full/empty, almost_full/almost_empty and sticky
// overflow/underflow flags. Storage must be read-before-write so a write
// into a full FIFO can be accepted alongside a read.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - fifo_status_ctrl_if.slave (requests in; enables, pointers, flags out)
// Optional feature macro: FIFO_STATUS_UNDERFLOW_EN
//   defined   - sticky underflow flag (read attempted while empty)
//   undefined - underflow tied to 0, no logic generated
module fifo_status_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_status_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL = AE_THRESH[ADDR_W:0];

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [ADDR_W:0] wptr_q, rptr_q;
  logic [ADDR_W:0] count_now, count_next;
  logic            full_now, empty_now;
  logic            we, re;
  logic            ovf_q;

  assign count_now = wptr_q - rptr_q;
  assign full_now  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign empty_now = (wptr_q == rptr_q);

  // A full FIFO still accepts a write when a read frees a slot this cycle.
  assign re = bus.rd & ~empty_now;
  assign we = bus.wr & (~full_now | re);

  assign count_next = count_now + (ADDR_W+1)'(we) - (ADDR_W+1)'(re);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (ADDR_W+1)'(we);
      rptr_q <= rptr_q + (ADDR_W+1)'(re);
    end
  end

  // Sticky overflow: set wins over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (bus.wr & full_now & ~re) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_err) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef FIFO_STATUS_UNDERFLOW_EN
  logic unf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unf_q <= 1'b0;
    end else if (bus.rd & empty_now) begin
      unf_q <= 1'b1;
    end else if (bus.clr_err) begin
      unf_q <= 1'b0;
    end
  end

  assign bus.underflow = unf_q;
`else
  assign bus.underflow = 1'b0;
`endif

  // Status FSM tracks the same condition as the full/empty equations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_EMPTY: begin
        if (we) begin
          state_next = (count_next == DEPTH) ? ST_FULL : ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (count_next == DEPTH) begin
          state_next = ST_FULL;
        end else if (count_next == '0) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (re & ~we) begin
          state_next = (count_next == '0) ? ST_EMPTY : ST_PARTIAL;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  assign bus.fifo_we      = we;
  assign bus.fifo_rd      = re;
  assign bus.wptr         = wptr_q;
  assign bus.rptr         = rptr_q;
  assign bus.count        = count_now;
  assign bus.full         = full_now;
  assign bus.empty        = empty_now;
  assign bus.almost_full  = (count_now >= AF_LVL);
  assign bus.almost_empty = (count_now <= AE_LVL);
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_fifo_status_ctrl.sv
module tb_fifo_status_ctrl;

  logic clk;
  logic rst;

  fifo_status_ctrl_if #(.ADDR_W(4)) bus ();

  fifo_status_ctrl #(
    .ADDR_W   (4),
    .AF_THRESH(12),
    .AE_THRESH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

`ifdef FIFO_STATUS_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [22:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state
  logic [4:0] m_w, m_r;
  logic       m_ov, m_uf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [22:0] pack(input logic we, re, input logic [4:0] wp, rp, cnt,
                                       input logic fl, em, af, ae, ov, uf);
    return {we, re, wp, rp, cnt, fl, em, af, ae, ov, uf};
  endfunction

  // Monitor: observes DUT shortly after each negedge (inputs settled).
  initial begin
    exp_t e;
    logic [22:0] obs;
    forever begin
      @(negedge clk);
      #1;
      n_checks++;
      if (((dut.state == 2'd2) != bus.full) || ((dut.state == 2'd0) != bus.empty)) begin
        n_fail++;
        $display("FAIL state_vs_flags: state=%0d full=%0b empty=%0b", dut.state, bus.full, bus.empty);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        obs = pack(bus.fifo_we, bus.fifo_rd, bus.wptr, bus.rptr, bus.count, bus.full,
                   bus.empty, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow);
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %06h expected %06h (we,rd,wp,rp,cnt,full,empty,af,ae,ov,uf)",
                   e.name, obs, e.v);
        end
      end
    end
  end

  task automatic push(input string name, input logic [22:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    q.push_back(e);
  endtask

  // One cycle of stimulus; expected response from the behavioural model.
  task automatic step(input logic w, r, c);
    logic [4:0] cnt;
    logic fl, em, re, we;
    @(negedge clk);
    bus.wr = w; bus.rd = r; bus.clr_err = c;
    cnt = m_w - m_r;
    fl  = (cnt == 5'd16);
    em  = (cnt == 5'd0);
    re  = r & ~em;
    we  = w & (~fl | re);
    push("model", pack(we, re, m_w, m_r, cnt, fl, em, cnt >= 5'd12, cnt <= 5'd4, m_ov, m_uf));
    if (w & fl & ~re) m_ov = 1'b1;
    else if (c)       m_ov = 1'b0;
    if (UF_EXP) begin
      if (r & em)     m_uf = 1'b1;
      else if (c)     m_uf = 1'b0;
    end
    m_w = m_w + 5'(we);
    m_r = m_r + 5'(re);
  endtask

  // Idle cycle checked against hand-computed constants.
  task automatic hand(input string name, input logic [4:0] wp, rp, cnt,
                      input logic fl, em, af, ae, ov, uf);
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
    push(name, pack(1'b0, 1'b0, wp, rp, cnt, fl, em, af, ae, ov, uf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
    m_w = '0; m_r = '0; m_ov = 1'b0; m_uf = 1'b0;
    push("reset", pack(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
    m_w = '0; m_r = '0; m_ov = 1'b0; m_uf = 1'b0;

    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    hand("idle_after_reset", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (16) step(1'b1, 1'b0, 1'b0);
    hand("filled", 5'd16, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0);
    hand("overflow_set", 5'd16, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    hand("overflow_set_wins", 5'd16, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    hand("overflow_cleared", 5'd16, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b0);
    hand("full_wr_rd", 5'd17, 5'd1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (16) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    hand("wrapped_empty", 5'd25, 5'd25, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0);
    hand("rd_while_empty", 5'd25, 5'd25, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, UF_EXP);
    step(1'b1, 1'b1, 1'b0);
    hand("wr_rd_while_empty", 5'd26, 5'd25, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, UF_EXP);
    step(1'b0, 1'b0, 1'b1);
    hand("underflow_cleared", 5'd26, 5'd25, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset asserted between clock edges while a write is pending
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    hand("after_mid_reset", 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    guard = 0;
    while (q.size() != 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
